// File: rtl/ir_prefetch_queue.sv
// ir_prefetch_queue: circular instruction prefetch queue between fetch and decode, with flush and sticky error flags.
// Optional IR_BYPASS_EN: an empty queue shows a word being loaded on ir_out in the same cycle.
module ir_prefetch_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OPC_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_ir,
    input  logic [WIDTH-1:0]         data_on_ir,
    input  logic                     take_ir,
    input  logic                     flush,
    output logic [WIDTH-1:0]         ir_out,
    output logic [OPC_W-1:0]         ir_opcode,
    output logic [WIDTH-OPC_W-1:0]   ir_operand,
    output logic                     ir_valid,
    output logic                     ir_full,
    output logic [$clog2(DEPTH):0]   ir_count,
    output logic                     ir_ovf,
    output logic                     ir_udf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             empty, full, byp, push_ok, pop_ok;

    assign empty = cnt_q == '0;
    assign full  = cnt_q == FULL_CNT;
`ifdef IR_BYPASS_EN
    assign byp = empty & load_ir & ~flush;
`else
    assign byp = 1'b0;
`endif
    // A bypassed word that decode takes immediately is never written into the queue.
    assign push_ok = load_ir & ~flush & (~full | take_ir) & ~(byp & take_ir);
    assign pop_ok  = take_ir & ~flush & ~empty;

    assign ir_out     = byp ? data_on_ir : (empty ? '0 : mem_q[rd_q]);
    assign ir_opcode  = ir_out[WIDTH-1 -: OPC_W];
    assign ir_operand = ir_out[WIDTH-OPC_W-1:0];
    assign ir_valid   = ~empty | byp;
    assign ir_full    = full;
    assign ir_count   = cnt_q;
    assign ir_ovf     = ovf_q;
    assign ir_udf     = udf_q;

    // Next-state: flush clears pointers and occupancy but leaves sticky flags alone.
    always_comb begin
        rd_d  = flush ? '0 : rd_q + AW'(pop_ok);
        wr_d  = flush ? '0 : wr_q + AW'(push_ok);
        cnt_d = flush ? '0 : cnt_q + CW'(push_ok) - CW'(pop_ok);
        ovf_d = ovf_q | (load_ir & ~flush & full & ~take_ir);
        udf_d = udf_q | (take_ir & ~flush & empty & ~byp);
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= data_on_ir;
    end
endmodule

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
- Parametrised successor to the single-entry instruction register. Holds up to DEPTH fetched instruction words in a circular queue.
- Sits between the instruction-fetch path (producer) and the decode stage (consumer).
- Presents the oldest word with its opcode and operand fields split out.
- Supports a pipeline flush on taken branches, plus overflow and underflow error flags.

Parameters:
- WIDTH, 8, instruction word width in bits (≥2).
- DEPTH, 4, number of queue entries (power of two, ≥2).
- OPC_W, 4, opcode field width (upper bits of the word; 1 ≤ OPC_W < WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_ir  input  1  push request; data_on_ir is written at the clock edge.
- data_on_ir  input  WIDTH  instruction word from fetch.
- take_ir  input  1  pop request from decode.
- flush  input  1  discard all queued words (branch taken).
- ir_out  output  WIDTH  head word; 0 when empty.
- ir_opcode  output  OPC_W  ir_out[WIDTH-1 -: OPC_W].
- ir_operand  output  WIDTH-OPC_W  ir_out[WIDTH-OPC_W-1:0].
- ir_valid  output  1  queue non-empty (head word is valid).
- ir_full  output  1  count == DEPTH.
- ir_count  output  $clog2(DEPTH)+1  number of occupied entries.
- ir_ovf  output  1  sticky flag: push attempted while full.
- ir_udf  output  1  sticky flag: pop attempted while empty.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): read and write pointers = 0, ir_count = 0, ir_ovf = 0, ir_udf = 0, ir_valid = 0, ir_full = 0, ir_out = 0. Storage contents need not be cleared.
- Storage: DEPTH × WIDTH register array. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is tracked by ir_count.
- ir_out, ir_opcode, ir_operand, ir_valid, ir_full are combinational from registered state. Read latency: a word pushed at edge N is visible on ir_out after edge N when the queue was empty. No same-cycle pass-through unless the optional feature is enabled.
- Event priority per edge:
  1. flush
  2. push/pop
- flush = 1: pointers = 0, ir_count = 0. Any load_ir or take_ir in the same cycle is ignored. Sticky flags are NOT cleared by flush.
- Push is accepted when load_ir = 1 and (count < DEPTH, or take_ir = 1 with count == DEPTH).
  - Full with simultaneous pop: both proceed, count unchanged.
  - Full without pop: push dropped, ir_ovf ← 1.
- Pop is accepted when take_ir = 1 and count > 0.
  - Empty with take_ir = 1: pop ignored, ir_udf ← 1. A simultaneous push still proceeds.
- Count update: +1 on push only, −1 on pop only, unchanged when both or neither are accepted.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: IR_BYPASS_EN.
- Defined:
  - When count == 0 and load_ir = 1, ir_out shows data_on_ir combinationally and ir_valid = 1 in the same cycle.
  - If take_ir = 1 in that cycle, the word is consumed with no write: count stays 0 and ir_udf is not set.
  - flush still overrides: bypass is suppressed when flush = 1.
- Not defined: no combinational path from data_on_ir to ir_out. Empty-cycle behaviour is exactly as in Behaviour.

Test Plan:
- Reset, then push 8'hA5, 8'h3C → ir_out = 8'hA5, ir_opcode = 4'hA, ir_operand = 4'h5, ir_count = 2. Pop → ir_out = 8'h3C, count = 1.
- Push 8'h11, 8'h22, 8'h33, 8'h44, then push 8'h55 → ir_full = 1, ir_ovf = 1, count = 4. Four pops return 11, 22, 33, 44; 8'h55 is never seen.
- Pointer wrap-around: fill to 4, then 6 cycles of simultaneous push/pop with 8'h60–8'h65 → count stays 4, ir_ovf stays 0. Output order is 8'h11, 22, 33, 44, 60, 61 during those cycles, with 8'h62–8'h65 remaining in order.
- Flush: with 3 entries queued, assert flush together with load_ir (8'h77) and take_ir → count = 0, ir_valid = 0, ir_out = 0. The next push of 8'h88 appears at the head.
- Pop while empty → ir_udf = 1, count stays 0. Without IR_BYPASS_EN, push 8'h99 + pop on empty → count = 1, ir_out = 8'h99 next cycle. With IR_BYPASS_EN, the same stimulus gives ir_out = 8'h99 and ir_valid = 1 that cycle, with count = 0 afterwards.
- Assert reset asynchronously between edges with 2 entries queued and ir_ovf = 1 → all outputs go to 0 immediately, without waiting for a clock edge.
